// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the pipeline MEM stage to the memory handler's data port. RV32
//   byte/half/word loads and stores are turned into word-aligned accesses.
//   Sub-word stores use a read-modify-write. Misaligned and illegal requests
//   complete with a fault and never reach memory. A per-state timeout stops
//   the unit from waiting forever on a missing dataMemorySuccess.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   reqValid               request present (accepted only while idle)
//   memRead, memWrite      load / store select (exactly one must be set)
//   funct3                 000 B, 001 H, 010 W, 100 BU, 101 HU
//   address, storeData     byte address; right-aligned store data
//   busy                   unit is not idle; the pipeline holds its request
//   respValid              one-cycle completion pulse
//   loadData               extended load result (0 unless respValid)
//   fault                  completion was misaligned / illegal / timed out
//   dataMemory*            word-aligned request/response to the memory handler
//
// All outputs come straight from registers. Each register is loaded with the
// value that belongs to the state being entered.

module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int TIMEOUT_WIDTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reqValid,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] storeData,
   output logic        busy,
   output logic        respValid,
   output logic [31:0] loadData,
   output logic        fault,
   output logic        dataMemoryReadEnable,
   output logic        dataMemoryWriteEnable,
   output logic [31:0] dataMemoryAddress,
   output logic [31:0] dataMemoryDataIn,
   input  logic        dataMemorySuccess,
   input  logic [31:0] dataMemoryDataOut
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      STORE     = 3'd2,
      RMW_READ  = 3'd3,
      RMW_WRITE = 3'd4,
      RESP      = 3'd5
   } lsuState_t;

   localparam logic [TIMEOUT_WIDTH-1:0] CNT_ZERO = {TIMEOUT_WIDTH{1'b0}};
   localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = TIMEOUT_WIDTH'(1'b1);
   // Last waiting cycle: counting 0..TIMEOUT_CYCLES-1 gives TIMEOUT_CYCLES waits.
   localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   // Pick the addressed lane from a read word and sign/zero extend it.
   function automatic logic [31:0] extendLoad(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
      logic [7:0]  byteVal;
      logic [15:0] halfVal;
      byteVal = word[{lane, 3'b000} +: 8];
      halfVal = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  extendLoad = {{24{byteVal[7]}}, byteVal};
         3'b100:  extendLoad = {24'h000000, byteVal};
         3'b001:  extendLoad = {{16{halfVal[15]}}, halfVal};
         3'b101:  extendLoad = {16'h0000, halfVal};
         3'b010:  extendLoad = word;
         default: extendLoad = 32'h0000_0000;
      endcase
   endfunction

   // Insert the low byte/half of the store data into the read word (little-endian).
   function automatic logic [31:0] mergeStore(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word,
                                              input logic [31:0] data);
      logic [31:0] result;
      result = word;
      case (f3)
         3'b000: result[{lane, 3'b000} +: 8] = data[7:0];
         3'b001: begin
            if (lane[1]) begin
               result[31:16] = data[15:0];
            end else begin
               result[15:0] = data[15:0];
            end
         end
         default: result = data;
      endcase
      mergeStore = result;
   endfunction

   lsuState_t          state_r, nextState_s;
   logic [TIMEOUT_WIDTH-1:0] cnt_r, nextCnt_s;
   logic [2:0]         funct3_r;
   logic [1:0]         lane_r;
   logic [31:0]        storeData_r;
   logic               capture_s;

   logic               readEn_r, nextReadEn_s;
   logic               writeEn_r, nextWriteEn_s;
   logic [31:0]        memAddr_r, nextMemAddr_s;
   logic [31:0]        memDataIn_r, nextMemDataIn_s;
   logic               respValid_r, nextRespValid_s;
   logic               fault_r, nextFault_s;
   logic [31:0]        loadData_r, nextLoadData_s;
   logic               busy_r, nextBusy_s;

   logic               validF3_s;
   logic               illegal_s;
   logic               misaligned_s;

   // Classify the incoming request: illegal encodings, then alignment.
   always_comb begin
      case (funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: validF3_s = 1'b1;
         default:                                validF3_s = 1'b0;
      endcase
      // BU/HU have funct3[2] set and only exist as loads.
      illegal_s = (memRead == memWrite) || !validF3_s || (memWrite && funct3[2]);
      case (funct3[1:0])
         2'b01:   misaligned_s = address[0];
         2'b10:   misaligned_s = (address[1:0] != 2'b00);
         default: misaligned_s = 1'b0;
      endcase
   end

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      nextState_s     = state_r;
      nextCnt_s       = CNT_ZERO;
      nextReadEn_s    = 1'b0;
      nextWriteEn_s   = 1'b0;
      nextMemAddr_s   = 32'h0000_0000;
      nextMemDataIn_s = 32'h0000_0000;
      nextFault_s     = 1'b0;
      nextLoadData_s  = 32'h0000_0000;
      capture_s       = 1'b0;

      case (state_r)
         IDLE: begin
            if (reqValid) begin
               capture_s = 1'b1;
               if (illegal_s || misaligned_s) begin
                  nextState_s = RESP;
                  nextFault_s = 1'b1;
               end else if (memRead) begin
                  nextState_s   = LOAD;
                  nextReadEn_s  = 1'b1;
                  nextMemAddr_s = {address[31:2], 2'b00};
               end else if (funct3 == 3'b010) begin
                  nextState_s     = STORE;
                  nextWriteEn_s   = 1'b1;
                  nextMemAddr_s   = {address[31:2], 2'b00};
                  nextMemDataIn_s = storeData;
               end else begin
                  nextState_s   = RMW_READ;
                  nextReadEn_s  = 1'b1;
                  nextMemAddr_s = {address[31:2], 2'b00};
               end
            end else begin
               nextState_s = IDLE;
            end
         end

         LOAD, STORE, RMW_READ, RMW_WRITE: begin
            if (dataMemorySuccess) begin
               if (state_r == RMW_READ) begin
                  // Read half of the RMW done: go straight to the write.
                  nextState_s     = RMW_WRITE;
                  nextWriteEn_s   = 1'b1;
                  nextMemAddr_s   = memAddr_r;
                  nextMemDataIn_s = mergeStore(funct3_r, lane_r, dataMemoryDataOut, storeData_r);
               end else if (state_r == LOAD) begin
                  nextState_s    = RESP;
                  nextLoadData_s = extendLoad(funct3_r, lane_r, dataMemoryDataOut);
               end else begin
                  nextState_s = RESP;
               end
            end else if (cnt_r == CNT_LAST) begin
               // Give up; a pending RMW write is dropped here.
               nextState_s = RESP;
               nextFault_s = 1'b1;
            end else begin
               nextState_s     = state_r;
               nextCnt_s       = cnt_r + CNT_ONE;
               nextReadEn_s    = readEn_r;
               nextWriteEn_s   = writeEn_r;
               nextMemAddr_s   = memAddr_r;
               nextMemDataIn_s = memDataIn_r;
            end
         end

         RESP: begin
            nextState_s = IDLE;
         end

         default: begin
            nextState_s = IDLE;
         end
      endcase

      nextRespValid_s = (nextState_s == RESP);
      nextBusy_s      = (nextState_s != IDLE);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         readEn_r    <= 1'b0;
         writeEn_r   <= 1'b0;
         memAddr_r   <= 32'h0000_0000;
         memDataIn_r <= 32'h0000_0000;
         respValid_r <= 1'b0;
         fault_r     <= 1'b0;
         loadData_r  <= 32'h0000_0000;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= nextState_s;
         cnt_r       <= nextCnt_s;
         readEn_r    <= nextReadEn_s;
         writeEn_r   <= nextWriteEn_s;
         memAddr_r   <= nextMemAddr_s;
         memDataIn_r <= nextMemDataIn_s;
         respValid_r <= nextRespValid_s;
         fault_r     <= nextFault_s;
         loadData_r  <= nextLoadData_s;
         busy_r      <= nextBusy_s;
      end
   end

   // Request fields kept for the whole transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         funct3_r    <= 3'b000;
         lane_r      <= 2'b00;
         storeData_r <= 32'h0000_0000;
      end else if (capture_s) begin
         funct3_r    <= funct3;
         lane_r      <= address[1:0];
         storeData_r <= storeData;
      end else begin
         funct3_r    <= funct3_r;
         lane_r      <= lane_r;
         storeData_r <= storeData_r;
      end
   end

   assign busy                  = busy_r;
   assign respValid             = respValid_r;
   assign loadData              = loadData_r;
   assign fault                 = fault_r;
   assign dataMemoryReadEnable  = readEn_r;
   assign dataMemoryWriteEnable = writeEn_r;
   assign dataMemoryAddress     = memAddr_r;
   assign dataMemoryDataIn      = memDataIn_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push their expected
// response; a negedge monitor pops and compares whenever respValid is high.

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqValid;
   logic        memRead;
   logic        memWrite;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] storeData;
   logic        busy;
   logic        respValid;
   logic [31:0] loadData;
   logic        fault;
   logic        dataMemoryReadEnable;
   logic        dataMemoryWriteEnable;
   logic [31:0] dataMemoryAddress;
   logic [31:0] dataMemoryDataIn;
   logic        dataMemorySuccess;
   logic [31:0] dataMemoryDataOut;

   load_store_unit #(.TIMEOUT_CYCLES(15), .TIMEOUT_WIDTH(4)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .reqValid              (reqValid),
      .memRead               (memRead),
      .memWrite              (memWrite),
      .funct3                (funct3),
      .address               (address),
      .storeData             (storeData),
      .busy                  (busy),
      .respValid             (respValid),
      .loadData              (loadData),
      .fault                 (fault),
      .dataMemoryReadEnable  (dataMemoryReadEnable),
      .dataMemoryWriteEnable (dataMemoryWriteEnable),
      .dataMemoryAddress     (dataMemoryAddress),
      .dataMemoryDataIn      (dataMemoryDataIn),
      .dataMemorySuccess     (dataMemorySuccess),
      .dataMemoryDataOut     (dataMemoryDataOut)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        fault;
      int          lat;
      int          reN;
      int          weN;
      int          issueCyc;
      int          reBase;
      int          weBase;
   } exp_t;

   exp_t        sbQ[$];
   int          vecs = 0;
   int          errs = 0;
   int          cyc = 0;
   int          done = 0;
   int          reTot = 0;
   int          weTot = 0;
   int          lastRespCyc = -1;

   // Memory model: responds in the same cycle as the enable when succEn is set.
   logic [31:0] mem [0:63];
   logic        succEn;
   logic        pokeEn;
   logic [5:0]  pokeIdx;
   logic [31:0] pokeVal;

   assign dataMemorySuccess = succEn && (dataMemoryReadEnable || dataMemoryWriteEnable);
   assign dataMemoryDataOut = mem[dataMemoryAddress[7:2]];

   // Memory array update: bench preload or DUT write.
   always @(posedge clk) begin
      if (pokeEn) begin
         mem[pokeIdx] <= pokeVal;
      end else if (dataMemoryWriteEnable && dataMemorySuccess) begin
         mem[dataMemoryAddress[7:2]] <= dataMemoryDataIn;
      end
   end

   // Cycle counter used to measure response latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: enable accounting, invariants and scoreboard comparison.
   always @(negedge clk) begin
      exp_t e;
      if (dataMemoryReadEnable) reTot++;
      if (dataMemoryWriteEnable) weTot++;
      if (dataMemoryReadEnable && dataMemoryWriteEnable) begin
         errs++;
         $display("FAIL both_enables at cycle %0d: got 1 expected 0", cyc);
      end
      if (!respValid && (loadData != 32'h0000_0000)) begin
         errs++;
         $display("FAIL loaddata_idle at cycle %0d: got %h expected 00000000", cyc, loadData);
      end
      if (respValid) begin
         lastRespCyc = cyc;
         if (sbQ.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_resp at cycle %0d: got respValid=1 expected 0", cyc);
         end else begin
            e = sbQ.pop_front();
            chk({e.name, "_data"},    loadData, e.data);
            chk({e.name, "_fault"},   {31'h0, fault}, {31'h0, e.fault});
            chk({e.name, "_latency"}, cyc - e.issueCyc, e.lat);
            chk({e.name, "_reads"},   reTot - e.reBase, e.reN);
            chk({e.name, "_writes"},  weTot - e.weBase, e.weN);
            done++;
         end
      end
   end

   task automatic poke(input logic [5:0] idx, input logic [31:0] val);
      @(posedge clk); #1;
      pokeEn = 1'b1; pokeIdx = idx; pokeVal = val;
      @(posedge clk); #1;
      pokeEn = 1'b0;
   endtask

   task automatic issue(input string name, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] eData, input logic eFault, input int eLat,
                        input int eRe, input int eWe);
      exp_t e;
      int   start;
      @(posedge clk); #1;
      memRead = rd; memWrite = wr; funct3 = f3; address = a; storeData = d;
      reqValid = 1'b1;
      e.name = name; e.data = eData; e.fault = eFault; e.lat = eLat;
      e.reN = eRe; e.weN = eWe; e.issueCyc = cyc; e.reBase = reTot; e.weBase = weTot;
      sbQ.push_back(e);
      start = done;
      @(posedge clk); #1;
      reqValid = 1'b0;
      for (int i = 0; i < 40 && done == start; i++) begin
         @(posedge clk); #1;
      end
      if (done == start) begin
         vecs++;
         errs++;
         $display("FAIL %s_no_resp: got none expected respValid within 40 cycles", name);
         sbQ.delete();
      end
      while (cyc <= lastRespCyc) begin
         @(posedge clk); #1;
      end
      chk({name, "_busy_after"}, {31'h0, busy}, 32'h0);
   endtask

   int weBefore;

   initial begin
      reset = 1'b1; reqValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
      funct3 = 3'b000; address = 32'h0; storeData = 32'h0;
      succEn = 1'b1; pokeEn = 1'b0; pokeIdx = 6'd0; pokeVal = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",   {31'h0, busy}, 32'h0);
      chk("rst_resp",   {31'h0, respValid}, 32'h0);
      chk("rst_fault",  {31'h0, fault}, 32'h0);
      chk("rst_ldata",  loadData, 32'h0);
      chk("rst_en",     {30'h0, dataMemoryReadEnable, dataMemoryWriteEnable}, 32'h0);
      chk("rst_addr",   dataMemoryAddress, 32'h0);
      chk("rst_din",    dataMemoryDataIn, 32'h0);
      reset = 1'b0;

      poke(6'd4, 32'h1122_3380);
      poke(6'd8, 32'h5566_7788);

      //     name     rd    wr    f3      addr         data          expData       flt  lat re we
      issue("lw10",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h1122_3380, 1'b0, 2, 1, 0);
      issue("lb10",  1'b1, 1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 1, 0);
      issue("lbu10", 1'b1, 1'b0, 3'b100, 32'h10, 32'h0,        32'h0000_0080, 1'b0, 2, 1, 0);
      issue("lh12",  1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'h0000_1122, 1'b0, 2, 1, 0);
      issue("lhu12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0,        32'h0000_1122, 1'b0, 2, 1, 0);

      issue("sb11",  1'b0, 1'b1, 3'b000, 32'h11, 32'h1234_56AB, 32'h0,        1'b0, 3, 1, 1);
      chk("sb11_mem", mem[4], 32'h1122_AB80);
      poke(6'd4, 32'h1122_3380);
      issue("sh12",  1'b0, 1'b1, 3'b001, 32'h12, 32'h5555_BEEF, 32'h0,        1'b0, 3, 1, 1);
      chk("sh12_mem", mem[4], 32'hBEEF_3380);
      issue("lh12n", 1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF_BEEF, 1'b0, 2, 1, 0);
      issue("lhu12n",1'b1, 1'b0, 3'b101, 32'h12, 32'h0,        32'h0000_BEEF, 1'b0, 2, 1, 0);
      issue("lb13",  1'b1, 1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFF_FFBE, 1'b0, 2, 1, 0);
      issue("lbu11", 1'b1, 1'b0, 3'b100, 32'h11, 32'h0,        32'h0000_0033, 1'b0, 2, 1, 0);
      issue("sw20",  1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 32'h0,        1'b0, 2, 0, 1);
      chk("sw20_mem", mem[8], 32'hCAFE_F00D);

      // Faulting requests: no memory traffic, response the next cycle.
      issue("lw13",  1'b1, 1'b0, 3'b010, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0, 0);
      issue("sh11",  1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFF,     32'h0,        1'b1, 1, 0, 0);
      issue("rdwr",  1'b1, 1'b1, 3'b010, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0);
      issue("none",  1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0);
      issue("sbu",   1'b0, 1'b1, 3'b100, 32'h10, 32'h12,       32'h0,        1'b1, 1, 0, 0);
      issue("f3_011",1'b1, 1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0);
      chk("fault_mem_kept", mem[4], 32'hBEEF_3380);

      // Missing success in LOAD: 15 waiting cycles, then a faulted response.
      succEn = 1'b0;
      issue("lw_tmo",1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h0,        1'b1, 16, 15, 0);
      succEn = 1'b1;

      // Reset while waiting in RMW_READ aborts the store silently.
      poke(6'd8, 32'h5566_7788);
      succEn = 1'b0;
      @(posedge clk); #1;
      memRead = 1'b0; memWrite = 1'b1; funct3 = 3'b000; address = 32'h21; storeData = 32'h77;
      reqValid = 1'b1;
      weBefore = weTot;
      @(posedge clk); #1;
      reqValid = 1'b0;
      chk("rst_mid_reading", {31'h0, dataMemoryReadEnable}, 32'h1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      succEn = 1'b1;
      chk("rst_mid_busy", {31'h0, busy}, 32'h0);
      chk("rst_mid_en",   {30'h0, dataMemoryReadEnable, dataMemoryWriteEnable}, 32'h0);
      chk("rst_mid_addr", dataMemoryAddress, 32'h0);
      chk("rst_mid_din",  dataMemoryDataIn, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_nowrite", weTot - weBefore, 32'h0);
      chk("rst_mid_mem",     mem[8], 32'h5566_7788);
      issue("lw_after", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0,     32'h5566_7788, 1'b0, 2, 1, 0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
